irq_aggregator: RTL and testbench
=================================

Name: irq_aggregator

Overview:
- Interrupt collector directly downstream of the counter/timer blocks.
- Takes the single-cycle or level `irq_out` lines of up to 32 timers and peripherals.
- Latches them into a pending register with a per-source mask and a per-source edge/level mode, plus overrun tracking.
- Presents one combined registered interrupt to the CPU, and a priority-encoded source ID for the handler.

Parameters:
- NSRC, 8, number of interrupt sources (legal 1..32); bits above NSRC-1 read 0 and ignore writes.

Ports:
- clkin  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- irq_in  input  NSRC  raw interrupt sources (e.g. counter_timer irq_out), bit i = source i
- reg_msk_we  input  4  byte write enables, mask register
- reg_msk_di  input  32  mask write data
- reg_msk_do  output  32  mask readback
- reg_mode_we  input  4  byte write enables, mode register
- reg_mode_di  input  32  mode write data (1 = edge, 0 = level)
- reg_mode_do  output  32  mode readback
- reg_pnd_we  input  4  byte write enables, pending register (write-1-to-clear)
- reg_pnd_di  input  32  pending clear data
- reg_pnd_do  output  32  pending readback
- reg_ovr_we  input  4  byte write enables, overrun register (write-1-to-clear)
- reg_ovr_di  input  32  overrun clear data
- reg_ovr_do  output  32  overrun readback
- reg_id_do  output  32  {valid, 26'd0, id[4:0]}
- irq_out  output  1  combined interrupt to CPU, registered

Behaviour:
- Reset (async, resetn low): mask, mode, pending, overrun, prev-sample and irq_out all 0. `reg_id_do` = 0.
- Sampled source `s[i]` is `irq_in[i]` directly; see the optional feature for the synchronised variant.
- `prev[i]` <= `s[i]` every cycle.
- Set event `set[i]`:
  - Edge mode: `s[i] & ~prev[i]`.
  - Level mode: `s[i]`.
  - `prev` resets to 0, so a source already high at reset release counts as an edge.
- Clear event `clr[i]`: byte `reg_pnd_we[i/8]` asserted and `reg_pnd_di[i]` = 1.
- Pending update: `pending[i]` <= `set[i] | (pending[i] & ~clr[i])`.
  - Set wins over a simultaneous clear; no event is lost.
  - Level-mode source still high after a clear re-pends on the same edge.
- Overrun, edge mode only: `set[i]` while `pending[i]` = 1 and `clr[i]` = 0 in the same cycle sets `ovr[i]`.
  - W1C through `reg_ovr_we`/`reg_ovr_di`, same byte rules.
  - Set wins over clear.
  - Level mode never sets `ovr`.
- Mask and mode: plain byte-enabled R/W.
  - Writing `mode` or `mask` never alters `pending` or `ovr`.
  - A mode change takes effect for the set evaluation on the next edge.
- Masking gates only `irq_out` and `reg_id_do`; masked sources still latch `pending` and `ovr`.
- Combine: `irq_out` <= OR over i of (`pending[i] & mask[i]`), evaluated on current register values.
- Latency, no sync: `irq_in` rise sampled at edge k gives `pending`=1 after edge k and `irq_out`=1 after edge k+1.
- Clear latency: clear written at edge k gives `irq_out`=0 after edge k+1, provided nothing else is pending.
- ID: combinational from `pending & mask`.
  - Lowest index wins.
  - valid = bit 31 = 1 when any bit is set, id in [4:0].
  - Nothing pending: whole word = 0.
- Writes to register bits at or above NSRC are ignored; those bits read 0.

Optional Feature:
- Macro: IRQ_AGGREGATOR_SYNC_EN.
- Defined:
  - Each `irq_in` bit passes through a 2-flop synchroniser (reset 0) before edge detection.
  - `s[i]` is the second flop; latency to `pending` and `irq_out` grows by 2 cycles.
  - Pulses shorter than one clkin period may be missed.
- Undefined:
  - `irq_in` is used directly; all sources must be synchronous to clkin.

Test Plan (no sync unless stated):
- Mode[0]=1, mask[0]=1; 1-cycle `irq_in[0]` pulse at edge 10 -> `pending[0]`=1 after edge 10, `irq_out`=1 after edge 11, `reg_id_do`=0x80000000. Then W1C pnd=0x1 -> `irq_out`=0 two edges later.
- Sources 5 and 2 both edge-pending, mask=0xFF -> `reg_id_do`=0x80000002. Clear bit 2 -> `reg_id_do`=0x80000005.
- Level mode bit 3, `irq_in[3]` held high, W1C bit 3 each cycle -> `pending[3]` stays 1 and `irq_out` stays 1. Drop `irq_in[3]`, then W1C -> `pending`=0, `irq_out`=0.
- Edge source 1, second pulse while `pending[1]`=1 -> `ovr`=0x2. Pulse coinciding with its W1C clear -> `pending[1]`=1 and `ovr` unchanged.
- mask=0, edge pulse on source 7 -> `pending`=0x80, `irq_out`=0, `reg_id_do`=0. Then mask=0x80 -> `irq_out`=1 one edge after the write.
- Assert resetn low mid-operation with `pending`=0xFF -> all registers and `irq_out` 0 immediately. With IRQ_AGGREGATOR_SYNC_EN, a pulse at edge 10 gives `pending`=1 after edge 12.

Source files
------------

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: pending/overrun latching with per-source mask and edge/level mode.
// Optional 2-flop input synchroniser enabled by defining IRQ_AGGREGATOR_SYNC_EN.
module irq_aggregator #(
    parameter int NSRC = 8
) (
    input  logic            clkin,
    input  logic            resetn,
    input  logic [NSRC-1:0] irq_in,
    input  logic [3:0]      reg_msk_we,
    input  logic [31:0]     reg_msk_di,
    output logic [31:0]     reg_msk_do,
    input  logic [3:0]      reg_mode_we,
    input  logic [31:0]     reg_mode_di,
    output logic [31:0]     reg_mode_do,
    input  logic [3:0]      reg_pnd_we,
    input  logic [31:0]     reg_pnd_di,
    output logic [31:0]     reg_pnd_do,
    input  logic [3:0]      reg_ovr_we,
    input  logic [31:0]     reg_ovr_di,
    output logic [31:0]     reg_ovr_do,
    output logic [31:0]     reg_id_do,
    output logic            irq_out
);

    logic [NSRC-1:0] msk_q, msk_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pnd_q, pnd_d;
    logic [NSRC-1:0] ovr_q, ovr_d;
    logic [NSRC-1:0] prev_q;
    logic            irq_q, irq_d;
    logic [NSRC-1:0] s;
    logic [NSRC-1:0] set_ev, clr_ev, ovr_set, ovr_clr;
    logic [31:0]     be_msk, be_mode, be_pnd, be_ovr;
    logic            unused_hi;

    function automatic logic [31:0] be_expand(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    // Lowest active index wins; an empty vector yields an all-zero word.
    function automatic logic [31:0] enc_id(input logic [NSRC-1:0] act);
        logic [31:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) r = {1'b1, 26'd0, 5'(i)};
        end
        return r;
    endfunction

`ifdef IRQ_AGGREGATOR_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = irq_in;
`endif

    assign be_msk  = be_expand(reg_msk_we);
    assign be_mode = be_expand(reg_mode_we);
    assign be_pnd  = be_expand(reg_pnd_we);
    assign be_ovr  = be_expand(reg_ovr_we);

    // Bits above NSRC-1 have no storage; fold them into one ignored net.
    assign unused_hi = ^{reg_msk_di, reg_mode_di, reg_pnd_di, reg_ovr_di,
                         be_msk, be_mode, be_pnd, be_ovr};

    always_comb begin
        msk_d   = (msk_q  & ~be_msk[NSRC-1:0])  | (reg_msk_di[NSRC-1:0]  & be_msk[NSRC-1:0]);
        mode_d  = (mode_q & ~be_mode[NSRC-1:0]) | (reg_mode_di[NSRC-1:0] & be_mode[NSRC-1:0]);
        set_ev  = (mode_q & s & ~prev_q) | (~mode_q & s);
        clr_ev  = be_pnd[NSRC-1:0] & reg_pnd_di[NSRC-1:0];
        pnd_d   = set_ev | (pnd_q & ~clr_ev);
        // Overrun only counts edge events that land on an uncleared pending bit.
        ovr_set = mode_q & set_ev & pnd_q & ~clr_ev;
        ovr_clr = be_ovr[NSRC-1:0] & reg_ovr_di[NSRC-1:0];
        ovr_d   = ovr_set | (ovr_q & ~ovr_clr);
        irq_d   = |(pnd_q & msk_q);
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            msk_q  <= '0;
            mode_q <= '0;
            pnd_q  <= '0;
            ovr_q  <= '0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            msk_q  <= msk_d;
            mode_q <= mode_d;
            pnd_q  <= pnd_d;
            ovr_q  <= ovr_d;
            prev_q <= s;
            irq_q  <= irq_d;
        end
    end

    assign reg_msk_do  = 32'(msk_q);
    assign reg_mode_do = 32'(mode_q);
    assign reg_pnd_do  = 32'(pnd_q);
    assign reg_ovr_do  = 32'(ovr_q);
    assign reg_id_do   = enc_id(pnd_q & msk_q);
    assign irq_out     = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed, table-driven bench for irq_aggregator (NSRC = 8, no input synchroniser).
module tb_irq_aggregator;

    logic        clkin = 1'b0;
    logic        resetn;
    logic [7:0]  irq_in;
    logic [3:0]  reg_msk_we, reg_mode_we, reg_pnd_we, reg_ovr_we;
    logic [31:0] reg_msk_di, reg_mode_di, reg_pnd_di, reg_ovr_di;
    logic [31:0] reg_msk_do, reg_mode_do, reg_pnd_do, reg_ovr_do, reg_id_do;
    logic        irq_out;

    int total = 0;
    int bad   = 0;

    irq_aggregator #(.NSRC(8)) dut (
        .clkin(clkin), .resetn(resetn), .irq_in(irq_in),
        .reg_msk_we(reg_msk_we),   .reg_msk_di(reg_msk_di),   .reg_msk_do(reg_msk_do),
        .reg_mode_we(reg_mode_we), .reg_mode_di(reg_mode_di), .reg_mode_do(reg_mode_do),
        .reg_pnd_we(reg_pnd_we),   .reg_pnd_di(reg_pnd_di),   .reg_pnd_do(reg_pnd_do),
        .reg_ovr_we(reg_ovr_we),   .reg_ovr_di(reg_ovr_di),   .reg_ovr_do(reg_ovr_do),
        .reg_id_do(reg_id_do), .irq_out(irq_out)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [7:0]  irq;
        logic [3:0]  mwe;  logic [31:0] mdi;
        logic [3:0]  dwe;  logic [31:0] ddi;
        logic [3:0]  pwe;  logic [31:0] pdi;
        logic [3:0]  owe;  logic [31:0] odi;
        logic [31:0] epnd; logic [31:0] eovr; logic [31:0] eid; logic eirq;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic idle_inputs();
        reg_msk_we = 4'h0;  reg_msk_di = 32'h0;
        reg_mode_we = 4'h0; reg_mode_di = 32'h0;
        reg_pnd_we = 4'h0;  reg_pnd_di = 32'h0;
        reg_ovr_we = 4'h0;  reg_ovr_di = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_msk"},  reg_msk_do, 32'h0);
        chk({tag, "_mode"}, reg_mode_do, 32'h0);
        chk({tag, "_pnd"},  reg_pnd_do, 32'h0);
        chk({tag, "_ovr"},  reg_ovr_do, 32'h0);
        chk({tag, "_id"},   reg_id_do, 32'h0);
        chk({tag, "_irq"},  32'(irq_out), 32'h0);
    endtask

    initial begin
        // Each row: inputs held for one clock, expectations read just after that edge.
        //          irq    mwe  mdi           dwe  ddi    pwe  pdi    owe  odi    pnd    ovr    id            irq
        vt[0]  = '{8'h00, 4'h1, 32'h000000FF, 4'h1, 32'h23, 4'h0, 32'h00, 4'h0, 32'h0, 32'h00, 32'h00, 32'h00000000, 1'b0};
        vt[1]  = '{8'h01, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h01, 32'h00, 32'h80000000, 1'b0};
        vt[2]  = '{8'h00, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h01, 32'h00, 32'h80000000, 1'b1};
        vt[3]  = '{8'h01, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h01, 32'h01, 32'h80000000, 1'b1};
        vt[4]  = '{8'h00, 4'h0, 32'h0,        4'h0, 32'h00, 4'h1, 32'h01, 4'h0, 32'h0, 32'h00, 32'h01, 32'h00000000, 1'b1};
        vt[5]  = '{8'h00, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h1, 32'h1, 32'h00, 32'h00, 32'h00000000, 1'b0};
        vt[6]  = '{8'h24, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h24, 32'h00, 32'h80000002, 1'b0};
        vt[7]  = '{8'h04, 4'h0, 32'h0,        4'h0, 32'h00, 4'h1, 32'h04, 4'h0, 32'h0, 32'h24, 32'h00, 32'h80000002, 1'b1};
        vt[8]  = '{8'h00, 4'h0, 32'h0,        4'h0, 32'h00, 4'h1, 32'h04, 4'h0, 32'h0, 32'h20, 32'h00, 32'h80000005, 1'b1};
        vt[9]  = '{8'h02, 4'h0, 32'h0,        4'h0, 32'h00, 4'h1, 32'h20, 4'h0, 32'h0, 32'h02, 32'h00, 32'h80000001, 1'b1};
        vt[10] = '{8'h00, 4'h1, 32'h00000000, 4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h02, 32'h00, 32'h00000000, 1'b1};
        vt[11] = '{8'h02, 4'h0, 32'h0,        4'h0, 32'h00, 4'h1, 32'h02, 4'h0, 32'h0, 32'h02, 32'h00, 32'h00000000, 1'b0};
        vt[12] = '{8'h02, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h02, 32'h00, 32'h00000000, 1'b0};
        vt[13] = '{8'h00, 4'h1, 32'h00000002, 4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h02, 32'h00, 32'h80000001, 1'b0};
        vt[14] = '{8'h00, 4'h0, 32'h0,        4'h0, 32'h00, 4'h0, 32'h00, 4'h0, 32'h0, 32'h02, 32'h00, 32'h80000001, 1'b1};
        vt[15] = '{8'h00, 4'h2, 32'hFFFFFFFF, 4'h2, 32'hFF, 4'h0, 32'h00, 4'h0, 32'h0, 32'h02, 32'h00, 32'h80000001, 1'b1};

        resetn = 1'b0;
        irq_in = 8'h00;
        idle_inputs();
        step();
        step();
        chk_all_zero("reset");
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            irq_in      = vt[i].irq;
            reg_msk_we  = vt[i].mwe; reg_msk_di  = vt[i].mdi;
            reg_mode_we = vt[i].dwe; reg_mode_di = vt[i].ddi;
            reg_pnd_we  = vt[i].pwe; reg_pnd_di  = vt[i].pdi;
            reg_ovr_we  = vt[i].owe; reg_ovr_di  = vt[i].odi;
            step();
            chk($sformatf("v%0d_pnd", i), reg_pnd_do, vt[i].epnd);
            chk($sformatf("v%0d_ovr", i), reg_ovr_do, vt[i].eovr);
            chk($sformatf("v%0d_id", i),  reg_id_do,  vt[i].eid);
            chk($sformatf("v%0d_irq", i), 32'(irq_out), 32'(vt[i].eirq));
        end
        idle_inputs();

        // Byte lanes above NSRC must not stick; readbacks hold only the low byte.
        chk("rb_msk",  reg_msk_do,  32'h00000002);
        chk("rb_mode", reg_mode_do, 32'h00000023);

        // All level mode and all sources high; bit 1 is still edge mode for this edge.
        irq_in = 8'hFF;
        reg_mode_we = 4'hF; reg_mode_di = 32'h0;
        reg_msk_we  = 4'hF; reg_msk_di  = 32'hFF;
        step();
        idle_inputs();
        chk("fill_pnd", reg_pnd_do, 32'hFF);
        chk("fill_ovr", reg_ovr_do, 32'h02);
        chk("fill_mode", reg_mode_do, 32'h0);
        step();
        chk("fill_irq", 32'(irq_out), 32'h1);
        chk("fill_id",  reg_id_do, 32'h80000000);

        // Asynchronous reset mid-cycle clears everything without waiting for an edge.
        #3;
        resetn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        irq_in = 8'h00;
        @(posedge clkin);
        #1;
        resetn = 1'b1;
        step();
        chk("post_rst_pnd", reg_pnd_do, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
